opb_err_cnt_bank: RTL and testbench

Multi-channel error-counter bank with an OPB slave readout port. It counts single-cycle error pulses on up to 32 independent channels, for example per-lane loopback or link checkers, in parallel. Software can freeze all channels atomically into snapshot registers, clear them, and select wrap or saturate mode. It sits on the PPC OPB bus beside the existing software-register slaves and runs entirely in the OPB clock domain; error inputs must already be synchronous to OPB_Clk.

---
 rtl/opb_err_cnt_bank.sv | 164 ++++++++++++++++
 tb/tb_opb_err_cnt_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_err_cnt_bank.sv
// OPB slave exposing a bank of per-channel error counters with atomic snapshot,
// clear and wrap/saturate control, all in the OPB clock domain.
module opb_err_cnt_bank #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_8400,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_84FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 8,
    parameter int          C_CNT_WIDTH  = 32
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [C_NUM_CH-1:0]         user_err_in,
    input  logic                        user_enable
);

    logic [31:0]            abus_s;
    logic [31:0]            wdata_s;
    logic [31:0]            off_s;
    logic [29:0]            word_s;
    logic                   in_window_s;
    logic                   accept_s;
    logic                   ctrl_wr_s;
    logic                   snap_s;
    logic                   clr_s;
    logic [31:0]            rd_s;
    logic                   unused_s;

    logic                   ack_q;
    logic                   hold_q;
    logic [31:0]            rdata_q;
    logic                   ctrl_wr_q;
    logic [2:0]             wdata_q;
    logic                   sat_q;
    logic [31:0]            snapcnt_q;
    logic [C_NUM_CH-1:0]    ovf_q;
    logic [C_NUM_CH-1:0]    ovf_d;
    logic [C_CNT_WIDTH-1:0] cnt_q  [C_NUM_CH];
    logic [C_CNT_WIDTH-1:0] cnt_d  [C_NUM_CH];
    logic [C_CNT_WIDTH-1:0] inc_s  [C_NUM_CH];
    logic [C_CNT_WIDTH-1:0] snap_q [C_NUM_CH];
    logic [C_CNT_WIDTH-1:0] snap_d [C_NUM_CH];

    assign abus_s      = OPB_ABus;
    assign wdata_s     = OPB_DBus;
    assign off_s       = abus_s - C_BASEADDR;
    assign word_s      = off_s[31:2];
    assign in_window_s = (abus_s >= C_BASEADDR) && (abus_s <= C_HIGHADDR);
    // The cycle after an ack is blocked too, so a held select needs an idle gap.
    assign accept_s    = OPB_select && in_window_s && !ack_q && !hold_q && !OPB_Rst;
    assign ctrl_wr_s   = ack_q && ctrl_wr_q;
    assign snap_s      = ctrl_wr_s && wdata_q[0];
    assign clr_s       = ctrl_wr_s && wdata_q[1];

    assign Sl_xferAck  = ack_q && !OPB_Rst;
    assign Sl_DBus     = OPB_Rst ? 32'h0 : rdata_q;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign unused_s    = ^{OPB_seqAddr, OPB_BE[0:2], wdata_s[31:3], off_s[1:0]};

    // Register-map read multiplexer, evaluated at acceptance.
    always_comb begin
        rd_s = 32'h0;
        case (word_s)
            30'd0: rd_s[2] = sat_q;
            30'd1: begin
                rd_s[5:0]  = 6'(C_NUM_CH);
                rd_s[13:8] = 6'(C_CNT_WIDTH);
            end
            30'd2: rd_s[C_NUM_CH-1:0] = ovf_q;
            30'd3: rd_s = snapcnt_q;
            default: begin
                for (int i = 0; i < C_NUM_CH; i++) begin
                    if (word_s == 30'(i + 4)) begin
                        rd_s[C_CNT_WIDTH-1:0] = snap_q[i];
                    end else begin
                        rd_s = rd_s;
                    end
                end
            end
        endcase
    end

    // Per-channel increment with wrap/saturate, then clear and snapshot selection.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < C_NUM_CH; i++) begin
            inc_s[i] = cnt_q[i];
            if (user_enable && user_err_in[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    inc_s[i] = sat_q ? cnt_q[i] : {C_CNT_WIDTH{1'b0}};
                end else begin
                    inc_s[i] = cnt_q[i] + C_CNT_WIDTH'(1);
                end
            end else begin
                inc_s[i] = cnt_q[i];
            end
            // The snapshot sees the pre-clear value including this cycle's increment.
            snap_d[i] = snap_s ? inc_s[i] : snap_q[i];
            cnt_d[i]  = clr_s ? {C_CNT_WIDTH{1'b0}} : inc_s[i];
        end
        if (clr_s) begin
            ovf_d = {C_NUM_CH{1'b0}};
        end else begin
            ovf_d = ovf_d;
        end
    end

    // Bus handshake, registered read data and control register.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ack_q     <= 1'b0;
            hold_q    <= 1'b0;
            rdata_q   <= 32'h0;
            ctrl_wr_q <= 1'b0;
            wdata_q   <= 3'b000;
            sat_q     <= 1'b0;
        end else begin
            ack_q     <= accept_s;
            hold_q    <= ack_q;
            rdata_q   <= (accept_s && OPB_RNW) ? rd_s : 32'h0;
            ctrl_wr_q <= accept_s && !OPB_RNW && (word_s == 30'd0) && OPB_BE[3];
            wdata_q   <= wdata_s[2:0];
            if (ctrl_wr_s) begin
                sat_q <= wdata_q[2];
            end
        end
    end

    // Live counters, overflow flags, snapshots and snapshot count.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ovf_q     <= {C_NUM_CH{1'b0}};
            snapcnt_q <= 32'h0;
            for (int i = 0; i < C_NUM_CH; i++) begin
                cnt_q[i]  <= {C_CNT_WIDTH{1'b0}};
                snap_q[i] <= {C_CNT_WIDTH{1'b0}};
            end
        end else begin
            ovf_q <= ovf_d;
            if (snap_s) begin
                snapcnt_q <= snapcnt_q + 32'd1;
            end
            for (int i = 0; i < C_NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

endmodule

// File: tb/tb_opb_err_cnt_bank.sv
// Scoreboard bench: two bank instances share one OPB bus (32-bit counters at
// 0x01008400, 4-bit counters at 0x01008500); read data is OR-combined as on OPB.
module tb_opb_err_cnt_bank;

    localparam logic [31:0] BA = 32'h0100_8400;
    localparam logic [31:0] BB = 32'h0100_8500;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] abus;
    logic [3:0]  be;
    logic [31:0] dbus;
    logic        rnw;
    logic        sel;
    logic [7:0]  err;
    logic        en;

    logic [31:0] dbus_a, dbus_b;
    logic        ack_a, ack_b;
    logic        erra_a, retry_a, tout_a, erra_b, retry_b, tout_b;
    logic [31:0] bus_dbus;
    logic        bus_ack;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        prev_ack = 1'b0;

    always #5 clk = ~clk;

    opb_err_cnt_bank #(.C_BASEADDR(BA), .C_HIGHADDR(32'h0100_84FF)) dut_a (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(1'b0), .Sl_DBus(dbus_a),
        .Sl_xferAck(ack_a), .Sl_errAck(erra_a), .Sl_retry(retry_a), .Sl_toutSup(tout_a),
        .user_err_in(err), .user_enable(en));

    opb_err_cnt_bank #(.C_BASEADDR(BB), .C_HIGHADDR(32'h0100_85FF), .C_CNT_WIDTH(4)) dut_b (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(1'b0), .Sl_DBus(dbus_b),
        .Sl_xferAck(ack_b), .Sl_errAck(erra_b), .Sl_retry(retry_b), .Sl_toutSup(tout_b),
        .user_err_in(err), .user_enable(en));

    assign bus_dbus = dbus_a | dbus_b;
    assign bus_ack  = ack_a | ack_b;

    // Monitor: every ack pops one expected entry; an ack must last one cycle.
    always @(negedge clk) begin
        if (bus_ack) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: got ack data=%h, required no ack", bus_dbus);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string       n = name_q.pop_front();
                if (bus_dbus !== e || (ack_a && ack_b) || erra_a || erra_b || retry_a || retry_b) begin
                    bad++;
                    $display("FAIL %s: got %h (acks a=%b b=%b), required %h", n, bus_dbus, ack_a, ack_b, e);
                end
            end
        end
        if (prev_ack) begin
            total++;
            if (bus_ack || bus_dbus != 32'h0) begin
                bad++;
                $display("FAIL ack_width: got ack=%b data=%h after ack cycle, required 0/0", bus_ack, bus_dbus);
            end
        end
        prev_ack = bus_ack;
    end

    task automatic xfer(input logic [31:0] addr, input logic r, input logic [31:0] wd,
                        input logic [3:0] b, input logic [31:0] e, input string nm,
                        input logic [7:0] ack_err);
        logic got;
        exp_q.push_back(r ? e : 32'h0);
        name_q.push_back(nm);
        @(posedge clk); #1;
        sel = 1'b1; abus = addr; rnw = r; dbus = wd; be = b;
        @(posedge clk); #1;
        err = ack_err;
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus_ack) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0; dbus = 32'h0; err = 8'h00;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ack in 8 cycles, required one ack", nm);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] e, input string nm);
        xfer(addr, 1'b1, 32'h0, 4'b1111, e, nm, 8'h00);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input string nm);
        xfer(addr, 1'b0, wd, 4'b1111, 32'h0, nm, 8'h00);
    endtask

    task automatic pulse(input logic [7:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            err = mask;
        end
        @(posedge clk); #1;
        err = 8'h00;
    endtask

    task automatic no_ack_window(input int n, input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus_ack) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL %s: got an ack, required none", nm);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; abus = 32'h0; be = 4'b0000; dbus = 32'h0; rnw = 1'b0;
        sel = 1'b0; err = 8'h00; en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus_ack !== 1'b0 || bus_dbus !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ack=%b data=%h, required 0/0", bus_ack, bus_dbus);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        rd(BA + 32'h4, 32'h0000_2008, "info_a");
        rd(BB + 32'h4, 32'h0000_0408, "info_b");
        rd(BA + 32'h8, 32'h0, "ovf_a_rst");
        rd(BA + 32'hC, 32'h0, "snapcnt_a_rst");
        for (int i = 0; i < 8; i++) rd(BA + 32'h10 + 32'(4 * i), 32'h0, "snap_a_rst");

        // Basic counting and snapshot
        pulse(8'h01, 5);
        pulse(8'h08, 1);
        wr(BA, 32'h1, "snap_a_1");
        rd(BA + 32'h10, 32'd5, "snap0_a");
        rd(BA + 32'h1C, 32'd1, "snap3_a");
        rd(BA + 32'h14, 32'd0, "snap1_a");
        rd(BA + 32'h2C, 32'd0, "snap7_a");
        rd(BA + 32'hC, 32'd1, "snapcnt_a_1");
        rd(BA, 32'h0, "ctrl_a_pulses_read0");
        rd(BB + 32'hC, 32'd0, "snapcnt_b_0");
        rd(BA + 32'h30, 32'h0, "unmapped_a");

        // 4-bit wrap, then saturate
        pulse(8'h02, 17);
        wr(BB, 32'h1, "snap_b_wrap");
        rd(BB + 32'h14, 32'd1, "snap1_b_wrap");
        rd(BB + 32'h8, 32'h2, "ovf_b_wrap");
        wr(BB, 32'h6, "clr_sat_b");
        pulse(8'h02, 17);
        wr(BB, 32'h5, "snap_b_sat");
        rd(BB + 32'h14, 32'd15, "snap1_b_sat");
        rd(BB + 32'h10, 32'd0, "snap0_b_after_clr");
        rd(BB + 32'h8, 32'h2, "ovf_b_sat");
        rd(BB, 32'h4, "ctrl_b_sat");
        rd(BB + 32'hC, 32'd2, "snapcnt_b_2");
        rd(BA + 32'h8, 32'h0, "ovf_a_none");

        // SNAP+CLR with a coincident pulse
        wr(BA, 32'h2, "clr_a");
        pulse(8'h04, 7);
        xfer(BA, 1'b0, 32'h3, 4'b1111, 32'h0, "snap_clr_a", 8'h04);
        rd(BA + 32'h18, 32'd8, "snap2_a_preclr");
        rd(BA + 32'h10, 32'd0, "snap0_a_cleared");
        rd(BA + 32'hC, 32'd2, "snapcnt_a_2");
        wr(BA, 32'h1, "snap_a_3");
        rd(BA + 32'h18, 32'd0, "snap2_a_postclr");
        rd(BA + 32'h8, 32'h0, "ovf_a_postclr");
        rd(BA + 32'hC, 32'd3, "snapcnt_a_3");

        // Enable low, then byte-enable gating
        en = 1'b0;
        pulse(8'h10, 10);
        wr(BA, 32'h1, "snap_a_4");
        rd(BA + 32'h20, 32'd0, "snap4_a_disabled");
        rd(BA + 32'hC, 32'd4, "snapcnt_a_4");
        en = 1'b1;
        pulse(8'h10, 3);
        xfer(BA, 1'b0, 32'h1, 4'b1110, 32'h0, "snap_a_be_off", 8'h00);
        rd(BA + 32'hC, 32'd4, "snapcnt_a_be_off");
        rd(BA + 32'h20, 32'd0, "snap4_a_be_off");

        // Reset in the would-be ack cycle of a read
        @(posedge clk); #1;
        sel = 1'b1; abus = BA + 32'hC; rnw = 1'b1; be = 4'b1111;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus_ack !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_xfer: got ack=%b, required 0", bus_ack);
        end
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        no_ack_window(3, "rst_no_late_ack");
        rd(BA + 32'hC, 32'd0, "snapcnt_a_after_rst");
        rd(BA + 32'h18, 32'd0, "snap2_a_after_rst");
        rd(BB + 32'h14, 32'd0, "snap1_b_after_rst");
        rd(BB + 32'h8, 32'h0, "ovf_b_after_rst");
        rd(BB, 32'h0, "ctrl_b_after_rst");
        rd(BB + 32'hC, 32'd0, "snapcnt_b_after_rst");

        // Out-of-window addresses
        @(posedge clk); #1;
        sel = 1'b1; abus = 32'h0100_8600; rnw = 1'b1;
        no_ack_window(4, "oow_above");
        abus = 32'h0100_83FC;
        no_ack_window(4, "oow_below");
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0;
        repeat (3) @(posedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
